// File: rtl/qa_channel_arbiter_pkg.sv
// Shared types for the QA request-channel arbiter: channel headers, frame
// requester bundles, grant pairs and request-type encodings.
package qa_channel_arbiter_pkg;

    typedef enum logic [3:0] {
        RdLine  = 4'h4,
        WrLine  = 4'h2,
        WrFence = 4'h5
    } t_req_type;

    typedef enum logic {
        READER = 1'b0,
        WRITER = 1'b1
    } last_winner_e;

    typedef struct packed {
        logic afu_en;
    } t_CSR_AFU_STATE;

    typedef struct packed {
        t_req_type   req_type;
        logic [31:0] address;
        logic [15:0] mdata;
    } tx_hdr_t;

    typedef struct packed {
        logic request;
    } req_t;

    typedef struct packed {
        req_t         read;
        tx_hdr_t      read_header;
        req_t         write;
        tx_hdr_t      write_header;
        logic [511:0] data;
    } frame_arb_t;

    typedef struct packed {
        logic rdvalid;
    } rx_c0_t;

    typedef struct packed {
        logic reader_grant;
        logic writer_grant;
    } channel_grant_arb_t;

    typedef struct packed {
        tx_hdr_t header;
        logic    rdvalid;
    } tx_c0_t;

    typedef struct packed {
        tx_hdr_t      header;
        logic [511:0] data;
        logic         wrvalid;
    } tx_c1_t;

endpackage

// File: rtl/qa_channel_arbiter_checker.sv
// Simulation checks on the outstanding-read credit counter.
module qa_channel_arbiter_checker #(
    parameter int CREDIT_WIDTH = 4
) (
    input logic                    clk,
    input logic                    resetb,
    input logic                    afu_en,
    input logic                    rdvalid,
    input logic [CREDIT_WIDTH-1:0] count
);

    credit_underflow_a: assert property (@(posedge clk) disable iff (!resetb)
        (afu_en && rdvalid) |-> (count != {CREDIT_WIDTH{1'b0}}))
        else $error("credit underflow");

endmodule

// File: rtl/qa_channel_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 is the reader, bit 1 the writer.
// A tie goes to whichever side did not win last.
module qa_rr_arb2
    import qa_channel_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       srst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    last_winner_e last_q;
    last_winner_e last_d;
    logic [1:0]   gnt_s;

    // Grant selection, same cycle as the request.
    always_comb begin
        gnt_s = 2'b00;
        if (!en_i) begin
            gnt_s = 2'b00;
        end else begin
            case (req_i)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = (last_q == READER) ? 2'b10 : 2'b01;
                default: gnt_s = 2'b00;
            endcase
        end
    end

    // Remember the most recent winner for the next tie.
    always_comb begin
        last_d = last_q;
        if (gnt_s[1]) begin
            last_d = WRITER;
        end else if (gnt_s[0]) begin
            last_d = READER;
        end else begin
            last_d = last_q;
        end
    end

    // Last-winner register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= READER;
        end else if (srst_i) begin
            last_q <= READER;
        end else begin
            last_q <= last_d;
        end
    end

    assign gnt_o = gnt_s;

endmodule

// File: rtl/qa_channel_arbiter.sv
// Arbitrates frame reader/writer requests onto QA tx0 (reads) and tx1
// (writes/fences), with a credit limit on outstanding reads.
module qa_channel_arbiter
    import qa_channel_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING_READS = 8,
    parameter int CREDIT_WIDTH          = 4
) (
    input  logic               clk,
    input  logic               resetb,
    input  t_CSR_AFU_STATE     csr,
    input  frame_arb_t         frame_reader,
    input  frame_arb_t         frame_writer,
    input  rx_c0_t             rx0,
    input  logic               c0_almost_full,
    input  logic               c1_almost_full,
    output channel_grant_arb_t read_grant,
    output channel_grant_arb_t write_grant,
    output tx_c0_t             tx0,
    output tx_c1_t             tx1
);

    localparam logic [CREDIT_WIDTH-1:0] MAX_C = CREDIT_WIDTH'(MAX_OUTSTANDING_READS);
    localparam logic [CREDIT_WIDTH-1:0] ONE_C = CREDIT_WIDTH'(1);

    logic                    srst_s;
    logic                    rd_en_s;
    logic                    wr_en_s;
    logic [1:0]              rd_gnt_s;
    logic [1:0]              wr_gnt_s;
    logic                    rsp_s;
    logic [CREDIT_WIDTH-1:0] count_q;
    logic [CREDIT_WIDTH-1:0] count_d;
    tx_c0_t                  tx0_q;
    tx_c0_t                  tx0_d;
    tx_c1_t                  tx1_q;
    tx_c1_t                  tx1_d;

    // Grants are masked by the async reset so they read 0 while it is held.
    assign srst_s  = !csr.afu_en;
    assign rd_en_s = resetb && csr.afu_en && !c0_almost_full && (count_q < MAX_C);
    assign wr_en_s = resetb && csr.afu_en && !c1_almost_full;
    assign rsp_s   = rx0.rdvalid && (count_q != {CREDIT_WIDTH{1'b0}});

    qa_rr_arb2 u_rd_arb (
        .clk    (clk),
        .rst_n  (resetb),
        .srst_i (srst_s),
        .req_i  ({frame_writer.read.request, frame_reader.read.request}),
        .en_i   (rd_en_s),
        .gnt_o  (rd_gnt_s)
    );

    qa_rr_arb2 u_wr_arb (
        .clk    (clk),
        .rst_n  (resetb),
        .srst_i (srst_s),
        .req_i  ({frame_writer.write.request, frame_reader.write.request}),
        .en_i   (wr_en_s),
        .gnt_o  (wr_gnt_s)
    );

    assign read_grant.reader_grant  = rd_gnt_s[0];
    assign read_grant.writer_grant  = rd_gnt_s[1];
    assign write_grant.reader_grant = wr_gnt_s[0];
    assign write_grant.writer_grant = wr_gnt_s[1];

    // Credit count: a grant and a response in the same cycle cancel.
    always_comb begin
        count_d = count_q;
        case ({|rd_gnt_s, rsp_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Channel payloads; header/data hold when nothing is granted.
    always_comb begin
        tx0_d         = tx0_q;
        tx1_d         = tx1_q;
        tx0_d.rdvalid = |rd_gnt_s;
        tx1_d.wrvalid = |wr_gnt_s;
        if (rd_gnt_s[1]) begin
            tx0_d.header = frame_writer.read_header;
        end else if (rd_gnt_s[0]) begin
            tx0_d.header = frame_reader.read_header;
        end else begin
            tx0_d.header = tx0_q.header;
        end
        if (wr_gnt_s[1]) begin
            tx1_d.header = frame_writer.write_header;
            tx1_d.data   = frame_writer.data;
        end else if (wr_gnt_s[0]) begin
            tx1_d.header = frame_reader.write_header;
            tx1_d.data   = frame_reader.data;
        end else begin
            tx1_d.header = tx1_q.header;
            tx1_d.data   = tx1_q.data;
        end
    end

    // Credit counter and channel output registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            count_q <= {CREDIT_WIDTH{1'b0}};
            tx0_q   <= '0;
            tx1_q   <= '0;
        end else if (srst_s) begin
            count_q <= {CREDIT_WIDTH{1'b0}};
            tx0_q   <= '0;
            tx1_q   <= '0;
        end else begin
            count_q <= count_d;
            tx0_q   <= tx0_d;
            tx1_q   <= tx1_d;
        end
    end

    assign tx0 = tx0_q;
    assign tx1 = tx1_q;

    qa_channel_arbiter_checker #(
        .CREDIT_WIDTH (CREDIT_WIDTH)
    ) u_checker (
        .clk     (clk),
        .resetb  (resetb),
        .afu_en  (csr.afu_en),
        .rdvalid (rx0.rdvalid),
        .count   (count_q)
    );

endmodule

// File: tb/tb_qa_channel_arbiter.sv
// Directed bench for qa_channel_arbiter: inputs driven on the falling edge,
// grants checked 1 ns later, registered channel outputs at the next falling edge.
module tb_qa_channel_arbiter;
    import qa_channel_arbiter_pkg::*;

    logic               clk = 1'b0;
    logic               resetb;
    t_CSR_AFU_STATE     csr;
    frame_arb_t         fr;
    frame_arb_t         fw;
    rx_c0_t             rx0;
    logic               c0_af;
    logic               c1_af;
    channel_grant_arb_t read_grant;
    channel_grant_arb_t write_grant;
    tx_c0_t             tx0;
    tx_c1_t             tx1;

    int errors = 0;
    int checks = 0;
    int gcount;

    always #5 clk = ~clk;

    qa_channel_arbiter #(
        .MAX_OUTSTANDING_READS (8),
        .CREDIT_WIDTH          (4)
    ) dut (
        .clk            (clk),
        .resetb         (resetb),
        .csr            (csr),
        .frame_reader   (fr),
        .frame_writer   (fw),
        .rx0            (rx0),
        .c0_almost_full (c0_af),
        .c1_almost_full (c1_af),
        .read_grant     (read_grant),
        .write_grant    (write_grant),
        .tx0            (tx0),
        .tx1            (tx1)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic tx_hdr_t mk(input t_req_type t, input logic [31:0] a);
        tx_hdr_t h;
        h          = '0;
        h.req_type = t;
        h.address  = a;
        return h;
    endfunction

    task automatic clr();
        fr  = '0;
        fw  = '0;
        rx0 = '0;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        resetb     = 1'b0;
        csr        = '0;
        csr.afu_en = 1'b1;
        c0_af      = 1'b0;
        c1_af      = 1'b0;
        clr();
        fr.read.request  = 1'b1;
        fw.write.request = 1'b1;
        #2;
        chk("rst_rd_gnt", read_grant.reader_grant, 1'b0);
        chk("rst_wr_gnt", write_grant.writer_grant, 1'b0);
        chk("rst_rdvalid", tx0.rdvalid, 1'b0);
        chk("rst_wrvalid", tx1.wrvalid, 1'b0);
        chk("rst_hdr", tx1.header, 52'h0);
        nxt();
        resetb = 1'b1;
        clr();

        // Lone writer WrLine.
        nxt();
        fw.write.request = 1'b1;
        fw.write_header  = mk(WrLine, 32'h1000);
        fw.data          = {16{32'hA5A5_0001}};
        #1;
        chk("t1_wgnt", write_grant.writer_grant, 1'b1);
        chk("t1_rgnt", write_grant.reader_grant, 1'b0);
        nxt();
        clr();
        chk("t1_wrvalid", tx1.wrvalid, 1'b1);
        chk("t1_addr", tx1.header.address, 32'h1000);
        chk("t1_data", tx1.data, {16{32'hA5A5_0001}});
        nxt();
        chk("t1_wrvalid_off", tx1.wrvalid, 1'b0);
        chk("t1_addr_hold", tx1.header.address, 32'h1000);

        // Both requesters read for 6 cycles: W,R,W,R,W,R.
        for (int i = 0; i < 6; i++) begin
            fr.read.request = 1'b1;
            fr.read_header  = mk(RdLine, 32'h200 + i);
            fw.read.request = 1'b1;
            fw.read_header  = mk(RdLine, 32'h300 + i);
            #1;
            chk("t2_w_gnt", read_grant.writer_grant, (i % 2 == 0));
            chk("t2_r_gnt", read_grant.reader_grant, (i % 2 == 1));
            nxt();
            chk("t2_rdvalid", tx0.rdvalid, 1'b1);
            chk("t2_addr", tx0.header.address, (i % 2 == 0) ? 32'h300 + i : 32'h200 + i);
        end
        clr();
        nxt();
        chk("t2_rdvalid_off", tx0.rdvalid, 1'b0);
        rx0.rdvalid = 1'b1;
        repeat (6) nxt();
        rx0.rdvalid = 1'b0;

        // Credit limit: 8 grants then stall; one response frees one grant.
        for (int i = 0; i < 10; i++) begin
            fr.read.request = 1'b1;
            fr.read_header  = mk(RdLine, 32'h400 + i);
            #1;
            chk("t3_gnt", read_grant.reader_grant, (i < 8));
            nxt();
        end
        rx0.rdvalid = 1'b1;
        #1;
        chk("t3_full_rsp_gnt", read_grant.reader_grant, 1'b0);
        nxt();
        rx0.rdvalid = 1'b0;
        chk("t3_stall_rdvalid", tx0.rdvalid, 1'b0);
        #1;
        chk("t3_refill_gnt", read_grant.reader_grant, 1'b1);
        nxt();
        chk("t3_refill_rdvalid", tx0.rdvalid, 1'b1);
        #1;
        chk("t3_full_again", read_grant.reader_grant, 1'b0);
        clr();
        rx0.rdvalid = 1'b1;
        repeat (3) nxt();
        rx0.rdvalid = 1'b0;

        // count=5: grant+response cancel; simultaneous read and write grants.
        fr.read.request  = 1'b1;
        fr.read_header   = mk(RdLine, 32'h500);
        rx0.rdvalid      = 1'b1;
        fw.write.request = 1'b1;
        fw.write_header  = mk(WrLine, 32'h2000);
        fw.data          = {16{32'h0BAD_CAFE}};
        #1;
        chk("t5_rd_gnt", read_grant.reader_grant, 1'b1);
        chk("t5_wr_gnt", write_grant.writer_grant, 1'b1);
        nxt();
        clr();
        chk("t5_rdvalid", tx0.rdvalid, 1'b1);
        chk("t5_wrvalid", tx1.wrvalid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            fr.read.request = 1'b1;
            #1;
            chk("t5_credit", read_grant.reader_grant, (i < 3));
            nxt();
        end
        clr();

        // WrFence held off by c1_almost_full for 3 cycles.
        c1_af            = 1'b1;
        fw.write.request = 1'b1;
        fw.write_header  = mk(WrFence, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_af_gnt", write_grant.writer_grant, 1'b0);
            nxt();
            chk("t4_af_wrvalid", tx1.wrvalid, 1'b0);
        end
        c1_af = 1'b0;
        #1;
        chk("t4_gnt", write_grant.writer_grant, 1'b1);
        nxt();
        clr();
        chk("t4_wrvalid", tx1.wrvalid, 1'b1);
        chk("t4_fence", tx1.header.req_type, WrFence);

        // Write-channel tie after writer won: reader first, then writer.
        fr.write.request = 1'b1;
        fr.write_header  = mk(WrLine, 32'h3000);
        fr.data          = {16{32'h1111_2222}};
        fw.write.request = 1'b1;
        fw.write_header  = mk(WrLine, 32'h3100);
        fw.data          = {16{32'h3333_4444}};
        #1;
        chk("t8_r_first", write_grant.reader_grant, 1'b1);
        chk("t8_w_wait", write_grant.writer_grant, 1'b0);
        nxt();
        chk("t8_addr_r", tx1.header.address, 32'h3000);
        chk("t8_data_r", tx1.data, {16{32'h1111_2222}});
        #1;
        chk("t8_w_next", write_grant.writer_grant, 1'b1);
        nxt();
        clr();
        chk("t8_data_w", tx1.data, {16{32'h3333_4444}});

        // Async reset mid-stream with count=3 and wrvalid=1.
        rx0.rdvalid = 1'b1;
        repeat (5) nxt();
        rx0.rdvalid      = 1'b0;
        fw.write.request = 1'b1;
        fw.write_header  = mk(WrLine, 32'h4000);
        nxt();
        chk("t6_pre_wrvalid", tx1.wrvalid, 1'b1);
        #2;
        resetb = 1'b0;
        #1;
        chk("t6_async_wrvalid", tx1.wrvalid, 1'b0);
        chk("t6_async_hdr", tx1.header.address, 32'h0);
        chk("t6_async_gnt", write_grant.writer_grant, 1'b0);
        nxt();
        resetb = 1'b1;
        clr();
        gcount = 0;
        for (int i = 0; i < 10; i++) begin
            fr.read.request = 1'b1;
            #1;
            if (read_grant.reader_grant) gcount++;
            nxt();
        end
        chk("t6_count_reset", gcount, 8);
        clr();

        // Soft reset via afu_en.
        fr.write.request = 1'b1;
        fr.write_header  = mk(WrLine, 32'h5000);
        fw.write.request = 1'b1;
        fw.write_header  = mk(WrLine, 32'h5100);
        #1;
        chk("t7_tie_after_rst", write_grant.writer_grant, 1'b1);
        nxt();
        chk("t7_wrvalid", tx1.wrvalid, 1'b1);
        csr.afu_en      = 1'b0;
        fr.read.request = 1'b1;
        #1;
        chk("t7_srst_wgnt_w", write_grant.writer_grant, 1'b0);
        chk("t7_srst_wgnt_r", write_grant.reader_grant, 1'b0);
        chk("t7_srst_rgnt", read_grant.reader_grant, 1'b0);
        nxt();
        chk("t7_srst_wrvalid", tx1.wrvalid, 1'b0);
        chk("t7_srst_hdr", tx1.header.address, 32'h0);
        chk("t7_srst_rdvalid", tx0.rdvalid, 1'b0);
        csr.afu_en      = 1'b1;
        fw.read.request = 1'b1;
        #1;
        chk("t7_rd_after_srst", read_grant.writer_grant, 1'b1);
        chk("t7_wr_after_srst", write_grant.writer_grant, 1'b1);
        nxt();
        clr();
        nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
